data_memory_ws: RTL
===================

# data_memory_ws

Parametrised, wait-stated data memory for the MEM stage of the pipelined datapath. Supports byte, halfword and word loads and stores, with sign or zero extension on loads. A programmable access latency is enforced by an internal counter FSM, and a `Busy` stall output lets the hazard unit freeze the pipeline while an access is in flight.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, 16..65536.
- `WAIT_STATES`, 1: extra cycles per access, 0..15.
- `Clk` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: reset; asynchronous, active-high.
- `Address` in 32: byte address; word index = `Address[log2(DEPTH_WORDS)+1:2]`; upper bits ignored (aliasing wrap).
- `WriteData` in 32: store data; the value sits in the low bits for byte/half stores.
- `MemWrite` in 1: store request.
- `MemRead` in 1: load request.
- `MemSize` in 2: access size: 00 byte, 01 half, 10 word, 11 word.
- `MemSigned` in 1: 1 = sign-extend loads, 0 = zero-extend loads.
- `ReadData` out 32: registered load result, held until the next load completes.
- `Busy` out 1: stall request to the pipeline (combinational).
- `Done` out 1: one-cycle pulse after an access commits.
- `AlignErr` out 1: misalignment flag; pulses with `Done` (see Configuration).

## Operation
- States:
  - IDLE: no access pending.
  - WAIT: access pending; a countdown counter `cnt` (4 bits) is active.
- Request = `MemRead | MemWrite`. If both are high, the access is a store and the read is ignored.
- Accepting a request in IDLE latches address, data, size, signed and direction, then:
  - `WAIT_STATES=0`: access performed at the acceptance edge; state stays IDLE.
  - `WAIT_STATES>0`: `cnt` loads `WAIT_STATES-1` and the FSM goes to WAIT.
- In WAIT, on each edge:
  - `cnt!=0`: decrement `cnt`.
  - `cnt==0`: perform the access, return to IDLE, and set `Done` for the next cycle.
- Requests seen while in WAIT are not accepted; the pipeline holds the same request stable under `Busy`.
- `Busy = (IDLE & request & WAIT_STATES!=0) | (WAIT & cnt!=0)`.
- Byte lanes are little-endian:
  - byte lane = `Address[1:0]`
  - half lane = `Address[1]`
- Store: read-modify-write of the addressed word; only the selected lanes change.
- Load: the selected lane is extended per `MemSigned` and registered into `ReadData`. Stores leave `ReadData` unchanged.
- Memory contents are not cleared by `Reset`; they are undefined until written.

## Timing
- Reset values:
  - state IDLE, `cnt=0`
  - `ReadData=0`, `Done=0`, `AlignErr=0`
  - `Busy` follows its equation (0 without a request).
- Request first presented in the cycle ending at edge N: commit at edge N+`WAIT_STATES`; `Done` and `ReadData` are valid in the following cycle.
- Throughput:
  - `WAIT_STATES=0`: one access per cycle, back-to-back, `Busy` never high.
  - `WAIT_STATES>0`: `WAIT_STATES+1` cycles per access.
- `Busy` is low in the commit cycle, so the pipeline advances on the same edge the access commits.
- Asserting `Reset` mid-access aborts it: no store committed, no `Done`, `ReadData` returns to 0.
- Address wrap: byte address `4*DEPTH_WORDS` aliases word 0.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A half access with `Address[0]=1`, or a word access with `Address[1:0]!=0`, is misaligned.
  - A misaligned access completes with normal latency, commits no store, and leaves `ReadData` unchanged.
  - `AlignErr` pulses together with `Done`.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - `AlignErr` is tied to 0.
  - Low address bits are masked to the natural alignment (half: bit0 = 0; word: bits[1:0] = 0) and the access proceeds.

## Test plan
- `WAIT_STATES=2`, SW `0xDEADBEEF` @0, then LW @0 -> `Busy` high for 2 cycles of each access, `Done` in cycle 4 of each, `ReadData=0xDEADBEEF`.
- SB `0x80` @5, then LB @5 and LBU @5 -> `0xFFFFFF80` and `0x00000080`; LW @4 -> byte 1 = `0x80`, other bytes unchanged.
- SH `0x8001` @2, then LH @2 -> `0xFFFF8001`; LHU @2 -> `0x00008001`; `MemRead` and `MemWrite` both high on a store -> treated as a store, `ReadData` unchanged.
- `Reset` pulsed in the second WAIT cycle of SW `0x1234` @8 -> later LW @8 returns the prior contents; `ReadData=0` and `Done=0` straight after reset.
- `WAIT_STATES=0`, back-to-back SW @0, SW @4, LW @0, LW @4 -> four `Done` pulses on consecutive cycles, `Busy` never high; LW at `4*DEPTH_WORDS` returns word 0.
- `DMEM_ALIGN_CHECK_EN`, LW @2 -> `AlignErr`=1 with `Done`, `ReadData` held; without the macro -> returns word @0.

Source files
------------

// File: rtl/data_memory_ws_if.sv
// Pipeline-to-data-memory bus: request fields from the MEM stage, load data and
// stall/completion status back from the memory.
interface data_memory_ws_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Done;
    logic        AlignErr;

    modport master (
        output Address, WriteData, MemWrite, MemRead, MemSize, MemSigned,
        input  ReadData, Busy, Done, AlignErr
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead, MemSize, MemSigned,
        output ReadData, Busy, Done, AlignErr
    );
endinterface

// File: rtl/data_memory_ws.sv
// Wait-stated byte/half/word data memory for the MEM stage with a countdown FSM.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses instead of masking them.
module data_memory_ws #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input logic           Clk,
    input logic           Reset,
    data_memory_ws_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam bit         ZWS      = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT = ZWS ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t         state, stateNxt;
    logic [3:0]     cnt, cntNxt;
    logic           req, accept, commit, busy;

    logic [AW+1:0]  addrQ;
    logic [31:0]    dataQ;
    logic [1:0]     sizeQ;
    logic           signedQ, writeQ;

    logic [AW+1:0]  accAddr;
    logic [31:0]    accData;
    logic [1:0]     accSize;
    logic           accSigned, accWrite;

    logic [AW-1:0]  idx;
    logic [1:0]     off;
    logic           misalign;
    logic [31:0]    curWord, laneMask, shifted, newWord, rsh, loadVal;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           unusedAddrHi;

    assign unusedAddrHi = &{1'b0, bus.Address[31:AW+2]};
    assign req          = bus.MemRead | bus.MemWrite;
    assign bus.Busy     = busy;

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        accept   = 1'b0;
        commit   = 1'b0;
        busy     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (ZWS) begin
                        commit = 1'b1;
                    end else begin
                        stateNxt = S_WAIT;
                        cntNxt   = CNT_INIT;
                        busy     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    cntNxt = cnt - 4'd1;
                    busy   = 1'b1;
                end else begin
                    commit   = 1'b1;
                    stateNxt = S_IDLE;
                end
            end
            default: stateNxt = S_IDLE;
        endcase
    end

    // With no wait states the access happens on the acceptance edge, so it
    // uses the live bus instead of the latched copy.
    always_comb begin
        if (ZWS) begin
            accAddr   = bus.Address[AW+1:0];
            accData   = bus.WriteData;
            accSize   = bus.MemSize;
            accSigned = bus.MemSigned;
            accWrite  = bus.MemWrite;
        end else begin
            accAddr   = addrQ;
            accData   = dataQ;
            accSize   = sizeQ;
            accSigned = signedQ;
            accWrite  = writeQ;
        end
        idx = accAddr[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = ((accSize == 2'b01) && accAddr[0]) ||
                   (accSize[1] && (accAddr[1:0] != 2'b00));
        off      = accAddr[1:0];
`else
        misalign = 1'b0;
        case (accSize)
            2'b00:   off = accAddr[1:0];
            2'b01:   off = {accAddr[1], 1'b0};
            default: off = 2'b00;
        endcase
`endif
        curWord = mem[idx];
        case (accSize)
            2'b00:   laneMask = 32'h0000_00FF << {off, 3'b000};
            2'b01:   laneMask = 32'h0000_FFFF << {off, 3'b000};
            default: laneMask = 32'hFFFF_FFFF;
        endcase
        shifted = accData << {off, 3'b000};
        newWord = (curWord & ~laneMask) | (shifted & laneMask);
        rsh     = curWord >> {off, 3'b000};
        case (accSize)
            2'b00:   loadVal = {{24{accSigned & rsh[7]}}, rsh[7:0]};
            2'b01:   loadVal = {{16{accSigned & rsh[15]}}, rsh[15:0]};
            default: loadVal = rsh;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            addrQ        <= '0;
            dataQ        <= 32'd0;
            sizeQ        <= 2'b00;
            signedQ      <= 1'b0;
            writeQ       <= 1'b0;
            bus.ReadData <= 32'd0;
            bus.Done     <= 1'b0;
            bus.AlignErr <= 1'b0;
        end else begin
            state        <= stateNxt;
            cnt          <= cntNxt;
            bus.Done     <= commit;
            bus.AlignErr <= commit & misalign;
            if (accept) begin
                addrQ   <= bus.Address[AW+1:0];
                dataQ   <= bus.WriteData;
                sizeQ   <= bus.MemSize;
                signedQ <= bus.MemSigned;
                writeQ  <= bus.MemWrite;
            end
            if (commit && !accWrite && !misalign)
                bus.ReadData <= loadVal;
        end
    end

    // Storage is deliberately outside the reset domain: contents survive Reset.
    always_ff @(posedge Clk) begin
        if (commit && accWrite && !misalign)
            mem[idx] <= newWord;
    end
endmodule
